// File: rtl/dot_operand_packer.sv
// Producer-side driver for the dotProduct engine: gathers DIM element pairs into the flat
// A/B buses, waits out the engine latency, then presents the captured dot product.
module dot_operand_packer #(
  parameter int DIM          = 10,
  parameter int A_DATA_WIDTH = 16,
  parameter int B_DATA_WIDTH = 16,
  parameter int RES_WIDTH    = 36,
  parameter int PIPE_LATENCY = 4
) (
  input  logic                      Clock,
  input  logic                      Reset,
  input  logic                      InValid,
  output logic                      InReady,
  input  logic [A_DATA_WIDTH-1:0]   InA,
  input  logic [B_DATA_WIDTH-1:0]   InB,
  input  logic                      InLast,
  output logic [A_DATA_WIDTH*DIM-1:0] A,
  output logic [B_DATA_WIDTH*DIM-1:0] B,
  input  logic [RES_WIDTH-1:0]      DotProduct,
  output logic                      ResValid,
  input  logic                      ResReady,
  output logic [RES_WIDTH-1:0]      Result,
  output logic                      LenError
);

  localparam int IDX_W = (DIM > 1) ? $clog2(DIM) : 1;
  localparam int CNT_W = (PIPE_LATENCY > 1) ? $clog2(PIPE_LATENCY) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIM - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PIPE_LATENCY - 1);

  typedef enum logic [1:0] {
    S_FILL = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [CNT_W-1:0] cnt;
  logic             accept;
  logic             at_last;

  assign InReady = (state == S_FILL);
  assign accept  = InValid && InReady;
  assign at_last = (idx == IDX_LAST);

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state    <= S_FILL;
      idx      <= '0;
      cnt      <= '0;
      A        <= '0;
      B        <= '0;
      Result   <= '0;
      ResValid <= 1'b0;
      LenError <= 1'b0;
    end else begin
      case (state)
        // Fill: one slot per accepted pair, vector closes on the DIM-th accept
        S_FILL: begin
          if (accept) begin
            for (int i = 0; i < DIM; i++) begin
              if (idx == IDX_W'(i)) begin
                A[i*A_DATA_WIDTH +: A_DATA_WIDTH] <= InA;
                B[i*B_DATA_WIDTH +: B_DATA_WIDTH] <= InB;
              end
            end
            // A misplaced InLast is only flagged; the element count still decides framing
            if (InLast != at_last) LenError <= 1'b1;
            if (at_last) begin
              idx   <= '0;
              cnt   <= '0;
              state <= S_WAIT;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        // Wait: A/B held stable while the engine pipeline settles
        S_WAIT: begin
          if (cnt == CNT_LAST) begin
            Result   <= DotProduct;
            ResValid <= 1'b1;
            state    <= S_HOLD;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        // Hold: result offered until the consumer takes it
        S_HOLD: begin
          if (ResReady) begin
            ResValid <= 1'b0;
            state    <= S_FILL;
          end
        end
        default: begin
          state    <= S_FILL;
          ResValid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dot_operand_packer.sv
// Bench for dot_operand_packer: directed scenarios plus random vectors against a slot-array
// reference model, with a pipelined engine model closing the A/B -> DotProduct loop.
module tb_dot_operand_packer;

  localparam int DIM = 10;
  localparam int AW  = 16;
  localparam int BW  = 16;
  localparam int RW  = 36;
  localparam int LAT = 4;

  logic               Clock;
  logic               Reset;
  logic               InValid;
  logic               InReady;
  logic [AW-1:0]      InA;
  logic [BW-1:0]      InB;
  logic               InLast;
  logic [AW*DIM-1:0]  A;
  logic [BW*DIM-1:0]  B;
  logic [RW-1:0]      DotProduct;
  logic               ResValid;
  logic               ResReady;
  logic [RW-1:0]      Result;
  logic               LenError;

  dot_operand_packer #(
    .DIM(DIM), .A_DATA_WIDTH(AW), .B_DATA_WIDTH(BW), .RES_WIDTH(RW), .PIPE_LATENCY(LAT)
  ) dut (
    .Clock(Clock), .Reset(Reset), .InValid(InValid), .InReady(InReady),
    .InA(InA), .InB(InB), .InLast(InLast), .A(A), .B(B),
    .DotProduct(DotProduct), .ResValid(ResValid), .ResReady(ResReady),
    .Result(Result), .LenError(LenError)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Engine model: combinational sum then LAT-1 registers, so DotProduct is valid
  // exactly in time for a capture LAT edges after A/B become complete.
  logic [RW-1:0] eng_sum;
  logic [RW-1:0] eng_pipe [LAT-1];
  always_comb begin
    eng_sum = '0;
    for (int i = 0; i < DIM; i++)
      eng_sum = eng_sum + RW'(A[i*AW +: AW]) * RW'(B[i*BW +: BW]);
  end
  always @(posedge Clock) begin
    eng_pipe[0] <= eng_sum;
    for (int i = 1; i < LAT - 1; i++) eng_pipe[i] <= eng_pipe[i-1];
  end
  assign DotProduct = eng_pipe[LAT-2];

  // Reference model
  int unsigned   checks = 0;
  int unsigned   errors = 0;
  logic [AW-1:0] ma [DIM];
  logic [BW-1:0] mb [DIM];
  int            midx;
  logic          mlen;

  function automatic logic [RW-1:0] model_sum();
    longint unsigned s = 0;
    for (int i = 0; i < DIM; i++) s += longint'(ma[i]) * longint'(mb[i]);
    return s[RW-1:0];
  endfunction

  function automatic logic [159:0] pack_a();
    logic [159:0] r = '0;
    for (int i = 0; i < DIM; i++) r[i*AW +: AW] = ma[i];
    return r;
  endfunction

  function automatic logic [159:0] pack_b();
    logic [159:0] r = '0;
    for (int i = 0; i < DIM; i++) r[i*BW +: BW] = mb[i];
    return r;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < DIM; i++) begin ma[i] = '0; mb[i] = '0; end
    midx = 0;
    mlen = 1'b0;
  endtask

  task automatic chk1(input string tag, input logic got, input logic exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0b exp=%0b", tag, got, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [159:0] got, input logic [159:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    @(negedge Clock);
    InValid = 1'b0;
    InA = AW'($urandom);
    InB = BW'($urandom);
    @(posedge Clock);
  endtask

  task automatic push(input logic [AW-1:0] a, input logic [BW-1:0] b, input logic last);
    int guard = 0;
    @(negedge Clock);
    InValid = 1'b1; InA = a; InB = b; InLast = last;
    while (!InReady && guard < 100) begin
      @(negedge Clock);
      guard++;
    end
    if (guard >= 100) begin
      checks++; errors++;
      $error("FAIL push_timeout got=InReady low exp=InReady high");
    end
    @(posedge Clock);
    ma[midx] = a;
    mb[midx] = b;
    if (last != (midx == DIM - 1)) mlen = 1'b1;
    midx = (midx == DIM - 1) ? 0 : midx + 1;
    #1;
    chk1("lenerror", LenError, mlen);
    InValid = 1'b0;
    InLast  = 1'b0;
  endtask

  task automatic push_vec(input logic [AW-1:0] a, input logic [BW-1:0] b);
    for (int i = 0; i < DIM; i++) push(a, b, i == DIM - 1);
  endtask

  // Call right after the closing accept; checks latency, value, hold and handshake.
  task automatic collect(input int hold, input logic [RW-1:0] exp_res);
    logic [RW-1:0] held;
    for (int k = 1; k <= LAT; k++) begin
      @(posedge Clock); #1;
      chk1("wait_inready", InReady, 1'b0);
      chk1("resvalid_latency", ResValid, k == LAT);
    end
    chkw("result_const", 160'(Result), 160'(exp_res));
    chkw("result_model", 160'(Result), 160'(model_sum()));
    chkw("bus_a", 160'(A), pack_a());
    chkw("bus_b", 160'(B), pack_b());
    held = Result;
    for (int h = 0; h < hold; h++) begin
      @(negedge Clock);
      InValid = 1'b1; InA = AW'($urandom); InB = BW'($urandom);
      @(posedge Clock); #1;
      chk1("hold_resvalid", ResValid, 1'b1);
      chk1("hold_inready", InReady, 1'b0);
      chkw("hold_result", 160'(Result), 160'(held));
    end
    @(negedge Clock);
    InValid = 1'b0;
    ResReady = 1'b1;
    @(posedge Clock); #1;
    ResReady = 1'b0;
    chk1("release_resvalid", ResValid, 1'b0);
    chk1("release_inready", InReady, 1'b1);
    chkw("hold_bus_a", 160'(A), pack_a());
    chkw("hold_bus_b", 160'(B), pack_b());
  endtask

  task automatic do_reset();
    @(negedge Clock);
    Reset = 1'b1;
    @(posedge Clock); #1;
    Reset = 1'b0;
    model_clear();
    chkw("rst_a", 160'(A), 160'(0));
    chkw("rst_b", 160'(B), 160'(0));
    chkw("rst_result", 160'(Result), 160'(0));
    chk1("rst_resvalid", ResValid, 1'b0);
    chk1("rst_lenerror", LenError, 1'b0);
    chk1("rst_inready", InReady, 1'b1);
  endtask

  initial begin
    Reset = 1'b1; InValid = 1'b0; InA = '0; InB = '0; InLast = 1'b0; ResReady = 1'b0;
    model_clear();
    repeat (3) @(posedge Clock);
    do_reset();

    // Equal elements, continuous valid
    push_vec(16'd8, 16'd8);
    chkw("t1_bus_a", 160'(A), {10{16'h0008}});
    collect(0, 36'd640);

    // Ramp with a gap before every element
    for (int i = 0; i < DIM; i++) begin
      idle();
      push(AW'(i + 1), 16'd2, i == DIM - 1);
    end
    collect(1, 36'd110);

    // Maximum operands must not wrap
    push_vec(16'hFFFF, 16'hFFFF);
    collect(2, 36'h9_FFEC_000A);

    // Long backpressure with InValid asserted
    push_vec(16'd7, 16'd5);
    collect(20, 36'd350);

    // Reset aborts a partial vector
    for (int i = 0; i < 5; i++) push(16'd9, 16'd9, 1'b0);
    do_reset();
    push_vec(16'd3, 16'd3);
    collect(0, 36'd90);

    // Early InLast: flagged, framing unchanged, sticky
    for (int i = 0; i < DIM; i++) push(AW'(i + 4), BW'(i + 1), i == 3);
    collect(1, model_sum());
    chk1("lenerror_sticky", LenError, 1'b1);
    push_vec(16'd1, 16'd1);
    collect(0, 36'd10);
    chk1("lenerror_still", LenError, 1'b1);
    do_reset();

    // Random vectors with random gaps and hold times
    for (int v = 0; v < 8; v++) begin
      for (int i = 0; i < DIM; i++) begin
        int gaps = $urandom_range(0, 2);
        for (int g = 0; g < gaps; g++) idle();
        push(AW'($urandom), BW'($urandom), i == DIM - 1);
      end
      collect($urandom_range(0, 3), model_sum());
    end
    chk1("random_lenerror", LenError, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
